// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: shares the register-file write port between the ALU result
// path (A) and the load result path (B). Each source feeds a small FIFO, one
// entry is popped per cycle round-robin, and a pending-write scoreboard shows
// which registers still have writes in flight.
module reg_wb_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   a_valid_i,
  input  logic [ADDR_W-1:0]      a_addr_i,
  input  logic [DATA_W-1:0]      a_data_i,
  output logic                   a_ready_o,
  input  logic                   b_valid_i,
  input  logic [ADDR_W-1:0]      b_addr_i,
  input  logic [DATA_W-1:0]      b_data_i,
  output logic                   b_ready_o,
  output logic                   RegWrite_o,
  output logic [ADDR_W-1:0]      RDaddr_o,
  output logic [DATA_W-1:0]      RDdata_o,
  output logic                   grant_o,
  output logic [(2**ADDR_W)-1:0] pending_o,
  output logic                   idle_o
);

  localparam int unsigned NSRC  = 2;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned NREG  = 2**ADDR_W;

  // FIFO storage, index 0 = source A, index 1 = source B
  logic [ADDR_W-1:0] addr_mem [NSRC][DEPTH];
  logic [DATA_W-1:0] data_mem [NSRC][DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q [NSRC];
  logic [PTR_W-1:0]  wr_ptr_d [NSRC];
  logic [PTR_W-1:0]  rd_ptr_q [NSRC];
  logic [PTR_W-1:0]  rd_ptr_d [NSRC];
  logic [CNT_W-1:0]  cnt_q    [NSRC];
  logic [CNT_W-1:0]  cnt_d    [NSRC];

  logic [ADDR_W-1:0] in_addr  [NSRC];
  logic [DATA_W-1:0] in_data  [NSRC];
  logic [NSRC-1:0]   in_valid;
  logic [NSRC-1:0]   ready;
  logic [NSRC-1:0]   push;
  logic [NSRC-1:0]   pop;
  logic [NSRC-1:0]   nonempty;

  logic              do_pop;
  logic              sel;

  logic              reg_write_q, reg_write_d;
  logic [ADDR_W-1:0] rd_addr_q,   rd_addr_d;
  logic [DATA_W-1:0] rd_data_q,   rd_data_d;
  logic              grant_q,     grant_d;
  logic [NREG-1:0]   pending;

  assign in_valid   = {b_valid_i, a_valid_i};
  assign in_addr[0] = a_addr_i;
  assign in_addr[1] = b_addr_i;
  assign in_data[0] = a_data_i;
  assign in_data[1] = b_data_i;

  // Ready from stored count only; writes to r0 complete the handshake but are dropped
  always_comb begin
    ready    = '0;
    push     = '0;
    nonempty = '0;
    for (int unsigned s = 0; s < NSRC; s++) begin
      ready[s]    = !rst_i && (cnt_q[s] < CNT_W'(DEPTH));
      nonempty[s] = (cnt_q[s] != '0);
      push[s]     = in_valid[s] && ready[s] && (in_addr[s] != '0);
    end
  end

  assign a_ready_o = ready[0];
  assign b_ready_o = ready[1];

  // Round-robin pick: under contention the source that did not win last goes
  always_comb begin
    do_pop      = |nonempty;
    sel         = 1'b0;
    pop         = '0;
    reg_write_d = 1'b0;
    rd_addr_d   = '0;
    rd_data_d   = '0;
    grant_d     = grant_q;
    if (nonempty[0] && nonempty[1]) begin
      sel = ~grant_q;
    end else if (nonempty[1]) begin
      sel = 1'b1;
    end
    if (do_pop) begin
      pop[sel]    = 1'b1;
      reg_write_d = 1'b1;
      rd_addr_d   = addr_mem[sel][rd_ptr_q[sel]];
      rd_data_d   = data_mem[sel][rd_ptr_q[sel]];
      grant_d     = sel;
    end
  end

  // FIFO pointer and occupancy update; push and pop in one edge leave count unchanged
  always_comb begin
    for (int unsigned s = 0; s < NSRC; s++) begin
      wr_ptr_d[s] = wr_ptr_q[s] + PTR_W'(push[s]);
      rd_ptr_d[s] = rd_ptr_q[s] + PTR_W'(pop[s]);
      cnt_d[s]    = cnt_q[s] + CNT_W'(push[s]) - CNT_W'(pop[s]);
    end
  end

  // Control state; reset leaves grant at B so A has priority first
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned s = 0; s < NSRC; s++) begin
        wr_ptr_q[s] <= '0;
        rd_ptr_q[s] <= '0;
        cnt_q[s]    <= '0;
      end
      reg_write_q <= 1'b0;
      rd_addr_q   <= '0;
      rd_data_q   <= '0;
      grant_q     <= 1'b1;
    end else begin
      for (int unsigned s = 0; s < NSRC; s++) begin
        wr_ptr_q[s] <= wr_ptr_d[s];
        rd_ptr_q[s] <= rd_ptr_d[s];
        cnt_q[s]    <= cnt_d[s];
      end
      reg_write_q <= reg_write_d;
      rd_addr_q   <= rd_addr_d;
      rd_data_q   <= rd_data_d;
      grant_q     <= grant_d;
    end
  end

  // FIFO payload storage; contents are only meaningful inside the valid window
  always_ff @(posedge clk_i) begin
    for (int unsigned s = 0; s < NSRC; s++) begin
      if (push[s]) begin
        addr_mem[s][wr_ptr_q[s]] <= in_addr[s];
        data_mem[s][wr_ptr_q[s]] <= in_data[s];
      end
    end
  end

  // Pending scoreboard: every queued entry plus the write currently on the port
  always_comb begin
    pending = '0;
    for (int unsigned s = 0; s < NSRC; s++) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (CNT_W'(i) < cnt_q[s]) begin
          pending[addr_mem[s][rd_ptr_q[s] + PTR_W'(i)]] = 1'b1;
        end
      end
    end
    if (reg_write_q) begin
      pending[rd_addr_q] = 1'b1;
    end
    pending[0] = 1'b0;
  end

  assign RegWrite_o = reg_write_q;
  assign RDaddr_o   = rd_addr_q;
  assign RDdata_o   = rd_data_q;
  assign grant_o    = grant_q;
  assign pending_o  = pending;
  assign idle_o     = !nonempty[0] && !nonempty[1] && !reg_write_q;

endmodule
